// File: rtl/cpu_int_ctrl.sv
// N-source interrupt controller on the CPU data bus: synchronises raw irqs, latches edges,
// masks, picks the lowest pending index and holds it in service until software writes EOI.
module cpu_int_ctrl #(
  parameter int unsigned NIRQ        = 8,
  parameter logic [31:0] EDGE        = 32'h0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      addr,
  input  logic [31:0]     din,
  output logic [31:0]     dout,
  input  logic [1:0]      drw,
  input  logic [NIRQ-1:0] irq,
  output logic            int_req,
  input  logic            int_ack
);

  localparam int unsigned IDW = 5;
  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_CUR  = 2'd2;
  localparam logic [1:0] A_EOI  = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     cur_id_q, cur_id_d, winner;
  logic [NIRQ-1:0]    sync_q [SYNC_STAGES];
  logic [NIRQ-1:0]    edge_mask, s, s_prev, rise;
  logic [NIRQ-1:0]    pend_edge, pend, mask, elig;
  logic [NIRQ-1:0]    clr_w1c, clr_ack;
  logic               wr_pend, wr_mask, wr_eoi;
  logic               unused_rd;

  // Read strobe carries no side effects; reads are purely combinational.
  assign unused_rd = drw[1];

  assign edge_mask = NIRQ'(EDGE);
  assign s         = sync_q[SYNC_STAGES-1];
  assign rise      = s & ~s_prev & edge_mask;
  assign pend      = (pend_edge & edge_mask) | (s & ~edge_mask);
  assign elig      = pend & mask;

  assign wr_pend = drw[0] && (addr == A_PEND);
  assign wr_mask = drw[0] && (addr == A_MASK);
  assign wr_eoi  = drw[0] && (addr == A_EOI);
  assign clr_w1c = wr_pend ? NIRQ'(din) : '0;

  // Input synchroniser plus previous-value flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      s_prev <= '0;
    end else begin
      sync_q[0] <= irq;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      s_prev <= s;
    end
  end

  // Edge latches and mask register; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_edge <= '0;
      mask      <= '0;
    end else begin
      pend_edge <= (pend_edge & ~(clr_w1c | clr_ack)) | rise;
      if (wr_mask) mask <= NIRQ'(din);
    end
  end

  // Fixed priority: lowest eligible index wins.
  always_comb begin
    winner = '0;
    for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
      if (elig[i]) winner = IDW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cur_id_q <= '0;
      int_req  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_id_q <= cur_id_d;
      int_req  <= (state_d == REQ);
    end
  end

  // Request/service sequencing; an ack outranks both a vanishing source and an EOI.
  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    clr_ack  = '0;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d  = REQ;
          cur_id_d = winner;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d = SERVICE;
          clr_ack = (NIRQ'(1) << cur_id_q) & edge_mask;
        end else if (!(|elig)) begin
          state_d = IDLE;
        end else begin
          cur_id_d = winner;
        end
      end
      SERVICE: begin
        if (wr_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout = '0;
    case (addr)
      A_PEND:  dout = 32'(pend);
      A_MASK:  dout = 32'(mask);
      A_CUR:   dout = {(state_q == SERVICE), 26'b0, cur_id_q};
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cpu_int_ctrl.sv
// Bench for cpu_int_ctrl: vector table, directed corner sequences and random traffic
// checked against a delay-line / phase model of the controller.
module tb_cpu_int_ctrl;

  localparam int          NIRQ = 8;
  localparam int          SS   = 2;
  localparam logic [31:0] EDGE = 32'h0000_00C3;
  localparam bit   [7:0]  E    = 8'hC3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [1:0]  drw;
  logic [7:0]  irq;
  logic        int_req;
  logic        int_ack;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_int_ctrl #(.NIRQ(NIRQ), .EDGE(EDGE), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout),
    .drw(drw), .irq(irq), .int_req(int_req), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Model: irq delay line, edge latch bits, mask and a phase (0 idle, 1 requesting, 2 in service).
  bit [7:0] m_dl[$];
  bit [7:0] m_prev, m_pe, m_mask;
  int       m_phase;
  bit [4:0] m_id;

  task automatic model_reset();
    m_dl.delete();
    repeat (SS) m_dl.push_back(8'h00);
    m_prev = 0; m_pe = 0; m_mask = 0; m_phase = 0; m_id = 0;
  endtask

  function automatic bit [7:0] m_pend();
    return (m_pe & E) | (m_dl[SS-1] & ~E);
  endfunction

  function automatic logic [31:0] m_dout(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_pend());
      2'd1:    return 32'(m_mask);
      2'd2:    return {(m_phase == 2), 26'b0, m_id};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    bit [7:0] s, elig, clr, dummy;
    int w;
    s    = m_dl[SS-1];
    elig = m_pend() & m_mask;
    clr  = (drw[0] && addr == 2'd0) ? din[7:0] : 8'h00;
    w = 0;
    if (elig != 0) while (!elig[w]) w++;
    if (m_phase == 0) begin
      if (elig != 0) begin m_phase = 1; m_id = 5'(w); end
    end else if (m_phase == 1) begin
      if (int_ack) begin
        m_phase = 2;
        if (E[m_id]) clr[m_id] = 1'b1;
      end else if (elig == 0) m_phase = 0;
      else m_id = 5'(w);
    end else begin
      if (drw[0] && addr == 2'd3) m_phase = 0;
    end
    m_pe = (m_pe & ~clr) | (s & ~m_prev & E);
    if (drw[0] && addr == 2'd1) m_mask = din[7:0];
    m_prev = s;
    m_dl.push_front(irq);
    dummy = m_dl.pop_back();
  endtask

  // One clock: advance the model, clock the DUT, drop strobes, compare int and read data.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    drw = 2'b00;
    int_ack = 1'b0;
    check("int", 32'(int_req), 32'(m_phase == 1));
    check("dout", dout, m_dout(addr));
  endtask

  task automatic wait_int(input logic target, input int max);
    int k = 0;
    while (int_req !== target && k < max) begin step(); k++; end
    check("wait_int", 32'(int_req), 32'(target));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; din = d; drw = 2'b01;
    step();
  endtask

  typedef struct {
    logic [7:0]  irq;
    logic [1:0]  addr;
    logic [1:0]  drw;
    logic [31:0] din;
    logic        ack;
    logic        exp_int;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t tv[10];

  initial begin
    int cnt;
    // Single edge on source 0: mask it in, pulse, ack, EOI.
    tv[0] = '{8'h00, 2'd1, 2'b01, 32'h1, 1'b0, 1'b0, 32'h1};
    tv[1] = '{8'h01, 2'd0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0};
    tv[2] = '{8'h00, 2'd0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0};
    tv[3] = '{8'h00, 2'd0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h1};
    tv[4] = '{8'h00, 2'd2, 2'b00, 32'h0, 1'b0, 1'b1, 32'h0};
    tv[5] = '{8'h00, 2'd2, 2'b00, 32'h0, 1'b1, 1'b0, 32'h8000_0000};
    tv[6] = '{8'h00, 2'd0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0};
    tv[7] = '{8'h00, 2'd3, 2'b01, 32'h0, 1'b0, 1'b0, 32'h0};
    tv[8] = '{8'h00, 2'd2, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0};
    tv[9] = '{8'h00, 2'd1, 2'b00, 32'h0, 1'b0, 1'b0, 32'h1};

    rst = 1'b0; irq = 8'hFF; addr = 2'd0; din = 0; drw = 2'b00; int_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_int", 32'(int_req), 32'h0);
    for (int a = 0; a < 3; a++) begin
      addr = 2'(a); #1;
      check("rst_reg", dout, 32'h0);
    end
    addr = 2'd0;
    #2 rst = 1'b1;
    repeat (6) step();
    check("masked_int", 32'(int_req), 32'h0);
    irq = 8'h00;
    repeat (4) step();
    wr(2'd0, 32'hFF);
    check("flush_pend", dout, 32'h0);

    for (int i = 0; i < 10; i++) begin
      irq = tv[i].irq; addr = tv[i].addr; drw = tv[i].drw; din = tv[i].din; int_ack = tv[i].ack;
      step();
      check($sformatf("vec%0d_int", i), 32'(int_req), 32'(tv[i].exp_int));
      check($sformatf("vec%0d_dout", i), dout, tv[i].exp_dout);
    end

    // Priority retarget: level 5 requesting, level 2 arrives before ack.
    wr(2'd1, 32'hFF);
    irq = 8'h20; addr = 2'd2;
    wait_int(1'b1, 10);
    irq = 8'h24;
    repeat (3) step();
    int_ack = 1'b1; step();
    check("prio_cur2", dout, 32'h8000_0002);
    irq = 8'h20;
    repeat (3) step();
    wr(2'd3, 32'h0);
    check("eoi_idle_int", 32'(int_req), 32'h0);
    addr = 2'd2; step();
    check("prio_reassert", 32'(int_req), 32'h1);
    check("prio_cur5_req", dout, 32'h0000_0005);
    int_ack = 1'b1; step();
    check("prio_cur5", dout, 32'h8000_0005);
    irq = 8'h00;
    repeat (3) step();
    wr(2'd3, 32'h0);

    // Level drop while requesting, no ack.
    irq = 8'h08;
    wait_int(1'b1, 10);
    irq = 8'h00; cnt = 0;
    while (int_req === 1'b1 && cnt < 6) begin step(); cnt++; end
    check("drop_latency_ok", 32'(cnt <= SS + 1), 32'h1);
    addr = 2'd2; #1;
    check("drop_cur", dout, 32'h0000_0003);

    // Edge reaching pend in the same cycle as a clear of that bit.
    wr(2'd1, 32'h0);
    irq = 8'h02;
    step(); step();
    wr(2'd0, 32'h2);
    check("w1c_race", dout, 32'h2);
    wr(2'd0, 32'h2);
    check("w1c_clear", dout, 32'h0);
    irq = 8'h00;
    repeat (3) step();

    // Asynchronous reset while in service.
    wr(2'd1, 32'hFF);
    irq = 8'h10;
    wait_int(1'b1, 10);
    int_ack = 1'b1; addr = 2'd2; step();
    check("svc_cur", dout, 32'h8000_0004);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("svc_rst_int", 32'(int_req), 32'h0);
    check("svc_rst_cur", dout, 32'h0);
    addr = 2'd1; #1;
    check("svc_rst_mask", dout, 32'h0);
    irq = 8'h00;
    @(posedge clk);
    #1 rst = 1'b1;
    wr(2'd3, 32'h0);
    check("rst_eoi_int", 32'(int_req), 32'h0);
    addr = 2'd2; #1;
    check("rst_eoi_cur", dout, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
      addr = 2'($urandom_range(0, 3));
      din  = $urandom;
      if (addr == 2'd1 && $urandom_range(0, 1) == 0) din = 32'hFF;
      drw  = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'($urandom_range(0, 1) << 1);
      int_ack = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
